// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, default sizing constants
// and the parity-type encoding also used by the parity generator.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_t;

    localparam int DEF_N            = 4;
    localparam int DEF_DW           = 8;
    localparam int DEF_BUSY_TIMEOUT = 4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the requesting blocks / UART TX top and the arbiter.
// The master side is the environment (requesters plus transmitter), the
// slave side is the arbiter itself.
interface uart_tx_arbiter_if #(
    parameter int N  = 4,
    parameter int DW = 8
);
    localparam int IW = $clog2(N);

    logic [N-1:0]    ARB_Req;
    logic [N*DW-1:0] ARB_Data;
    logic [N-1:0]    ARB_ParEn;
    logic [N-1:0]    ARB_ParType;
    logic [N-1:0]    ARB_Gnt;
    logic [DW-1:0]   ARB_TxData;
    logic            ARB_TxParEn;
    logic            ARB_TxParType;
    logic            ARB_TxDataValid;
    logic            ARB_TxBusy;
    logic [IW-1:0]   ARB_Owner;
    logic            ARB_Active;
    logic            ARB_ErrTimeout;
    logic            ARB_ErrClr;

    modport master (
        output ARB_Req, ARB_Data, ARB_ParEn, ARB_ParType, ARB_TxBusy, ARB_ErrClr,
        input  ARB_Gnt, ARB_TxData, ARB_TxParEn, ARB_TxParType, ARB_TxDataValid,
               ARB_Owner, ARB_Active, ARB_ErrTimeout
    );

    modport slave (
        input  ARB_Req, ARB_Data, ARB_ParEn, ARB_ParType, ARB_TxBusy, ARB_ErrClr,
        output ARB_Gnt, ARB_TxData, ARB_TxParEn, ARB_TxParType, ARB_TxDataValid,
               ARB_Owner, ARB_Active, ARB_ErrTimeout
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request scanning upward from
// ptr, wrapping at N-1.
module rr_picker #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] winIdx,
    output logic          winValid
);

    // candIdx[k] is the requester examined at scan offset k from ptr
    logic [IW-1:0] candIdx [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            logic [IW:0] sum;
            assign sum          = {1'b0, ptr} + (IW+1)'(gi);
            assign candIdx[gi]  = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
        end
    endgenerate

    // Scan from the farthest offset down so the nearest pending request wins
    always_comb begin
        winIdx   = '0;
        winValid = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[candIdx[k]]) begin
                winIdx   = candIdx[k];
                winValid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between N requesters.
// Captures the winner's byte and parity setup, pulses DataValid with a
// one-cycle grant, then follows the transmitter Busy flag to frame end.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N            = DEF_N,
    parameter int DW           = DEF_DW,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic                   ARB_CLK,
    input  logic                   ARB_RST_ASYN,
    uart_tx_arbiter_if.slave       arb
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    arb_state_t    stateReg, stateNext;
    logic [IW-1:0] rrPtrReg, rrPtrNext;
    logic [IW-1:0] ownerReg, ownerNext;
    logic [N-1:0]  gntReg, gntNext;
    logic [DW-1:0] txDataReg, txDataNext;
    logic          txParEnReg, txParEnNext;
    logic          txParTypeReg, txParTypeNext;
    logic          txDataValidReg, txDataValidNext;
    logic          activeReg, activeNext;
    logic          errTimeoutReg, errTimeoutNext;
    logic [CW-1:0] cntReg, cntNext;

    logic [IW-1:0] pickIdx;
    logic          pickValid;

    rr_picker #(.N(N)) uPicker (
        .req      (arb.ARB_Req),
        .ptr      (rrPtrReg),
        .winIdx   (pickIdx),
        .winValid (pickValid)
    );

    // State and output registers; every output comes straight from a flop
    always_ff @(posedge ARB_CLK or negedge ARB_RST_ASYN) begin
        if (!ARB_RST_ASYN) begin
            stateReg       <= ST_IDLE;
            rrPtrReg       <= '0;
            ownerReg       <= '0;
            gntReg         <= '0;
            txDataReg      <= '0;
            txParEnReg     <= 1'b0;
            txParTypeReg   <= 1'b0;
            txDataValidReg <= 1'b0;
            activeReg      <= 1'b0;
            errTimeoutReg  <= 1'b0;
            cntReg         <= '0;
        end else begin
            stateReg       <= stateNext;
            rrPtrReg       <= rrPtrNext;
            ownerReg       <= ownerNext;
            gntReg         <= gntNext;
            txDataReg      <= txDataNext;
            txParEnReg     <= txParEnNext;
            txParTypeReg   <= txParTypeNext;
            txDataValidReg <= txDataValidNext;
            activeReg      <= activeNext;
            errTimeoutReg  <= errTimeoutNext;
            cntReg         <= cntNext;
        end
    end

    // Next-state logic; Gnt/DataValid are computed one state early so they
    // are registered high exactly during SEND
    always_comb begin
        stateNext       = stateReg;
        rrPtrNext       = rrPtrReg;
        ownerNext       = ownerReg;
        gntNext         = '0;
        txDataNext      = txDataReg;
        txParEnNext     = txParEnReg;
        txParTypeNext   = txParTypeReg;
        txDataValidNext = 1'b0;
        cntNext         = cntReg;
        // A timeout raised below overrides this clear
        errTimeoutNext  = errTimeoutReg & ~arb.ARB_ErrClr;

        case (stateReg)
            ST_IDLE: begin
                if (pickValid && !arb.ARB_TxBusy) begin
                    stateNext       = ST_SEND;
                    ownerNext       = pickIdx;
                    txDataNext      = arb.ARB_Data[int'(pickIdx)*DW +: DW];
                    txParEnNext     = arb.ARB_ParEn[pickIdx];
                    txParTypeNext   = arb.ARB_ParType[pickIdx];
                    txDataValidNext = 1'b1;
                    gntNext         = N'(1) << pickIdx;
                end
            end
            ST_SEND: begin
                rrPtrNext = (ownerReg == IW'(N - 1)) ? '0 : ownerReg + 1'b1;
                cntNext   = '0;
                stateNext = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (arb.ARB_TxBusy) begin
                    stateNext = ST_WAIT_DONE;
                end else if (cntReg == CW'(BUSY_TIMEOUT - 1)) begin
                    cntNext        = cntReg + 1'b1;
                    errTimeoutNext = 1'b1;
                    stateNext      = ST_IDLE;
                end else begin
                    cntNext = cntReg + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!arb.ARB_TxBusy) begin
                    stateNext = ST_IDLE;
                end
            end
            default: stateNext = ST_IDLE;
        endcase

        activeNext = (stateNext != ST_IDLE);
    end

    assign arb.ARB_Gnt         = gntReg;
    assign arb.ARB_TxData      = txDataReg;
    assign arb.ARB_TxParEn     = txParEnReg;
    assign arb.ARB_TxParType   = txParTypeReg;
    assign arb.ARB_TxDataValid = txDataValidReg;
    assign arb.ARB_Owner       = ownerReg;
    assign arb.ARB_Active      = activeReg;
    assign arb.ARB_ErrTimeout  = errTimeoutReg;

endmodule
